// File: rtl/sensor_emul_tx.sv
// -----------------------------------------------------------------------------
// sensor_emul_tx
// Emulates the pad-level output of a parallel CMOS sensor: frame valid (vact),
// line valid (hact) and pixel data (pxd) built from a programmable frame
// geometry and a test pattern. Obeys the sensor master reset (mrst) and the
// trigger pin (aro), so the acquisition chain can run without a real sensor.
//
// Ports
//   clk          pixel clock, all logic on its rising edge
//   rst          asynchronous active-high reset
//   mrst         sensor master reset, active-low, synchronous effect
//   aro          trigger pin (asynchronous), used only when trig_mode=1
//   en           enable frame generation
//   trig_mode    0: free-run, 1: one frame per aro rising edge
//   hact_length  active pixels per line minus 1
//   vact_length  active lines per frame minus 1
//   hblank       horizontal blank cycles minus 1 (also frame front porch)
//   vblank       vertical blank cycles minus 1
//   pattern      0 column ramp, 1 row ramp, 2 col+row+frame, 3 constant 0xAAA
//   vact         frame valid (registered)
//   hact         line valid (registered)
//   pxd          pixel data, aligned with hact, zero otherwise (registered)
//   frame_done   one-cycle pulse on the first vertical blank cycle
// -----------------------------------------------------------------------------
module sensor_emul_tx #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mrst,
  input  logic                  aro,
  input  logic                  en,
  input  logic                  trig_mode,
  input  logic [CNT_WIDTH-1:0]  hact_length,
  input  logic [CNT_WIDTH-1:0]  vact_length,
  input  logic [CNT_WIDTH-1:0]  hblank,
  input  logic [CNT_WIDTH-1:0]  vblank,
  input  logic [1:0]            pattern,
  output logic                  vact,
  output logic                  hact,
  output logic [DATA_WIDTH-1:0] pxd,
  output logic                  frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FPORCH,
    S_LINE,
    S_HBLANK,
    S_VBLANK
  } state_t;

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;       // blank counter or column, per state
  logic [CNT_WIDTH-1:0]  r_row;
  logic [DATA_WIDTH-1:0] r_frame;     // frame counter, wraps with pixel width
  logic [CNT_WIDTH-1:0]  r_hact_len;
  logic [CNT_WIDTH-1:0]  r_vact_len;
  logic [CNT_WIDTH-1:0]  r_hblank;
  logic [CNT_WIDTH-1:0]  r_vblank;
  logic [1:0]            r_pattern;
  logic                  r_aro_meta;
  logic                  r_aro_sync;
  logic                  r_aro_dly;
  logic                  r_vact;
  logic                  r_hact;
  logic [DATA_WIDTH-1:0] r_pxd;
  logic                  r_frame_done;

  state_t                w_nxt_state;
  logic [CNT_WIDTH-1:0]  w_nxt_cnt;
  logic [CNT_WIDTH-1:0]  w_nxt_row;
  logic [DATA_WIDTH-1:0] w_nxt_frame;
  logic                  w_load;
  logic                  w_nxt_done;
  logic                  w_nxt_vact;
  logic                  w_nxt_hact;
  logic [DATA_WIDTH-1:0] w_pix;
  logic                  w_aro_rise;
  logic                  w_start;

  assign w_aro_rise = r_aro_sync & ~r_aro_dly;
  assign w_start    = en && mrst && (!trig_mode || w_aro_rise);

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_row   = r_row;
    w_nxt_frame = r_frame;
    w_load      = 1'b0;
    w_nxt_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_nxt_cnt = '0;
        w_nxt_row = '0;
        if (w_start) begin
          w_nxt_state = S_FPORCH;
          w_load      = 1'b1;
        end
      end
      S_FPORCH, S_HBLANK: begin
        if (r_cnt == r_hblank) begin
          w_nxt_state = S_LINE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CNT_WIDTH'(1);
        end
      end
      S_LINE: begin
        if (r_cnt == r_hact_len) begin
          w_nxt_cnt = '0;
          if (r_row == r_vact_len) begin
            w_nxt_state = S_VBLANK;
            w_nxt_done  = 1'b1;
          end else begin
            w_nxt_state = S_HBLANK;
            w_nxt_row   = r_row + CNT_WIDTH'(1);
          end
        end else begin
          w_nxt_cnt = r_cnt + CNT_WIDTH'(1);
        end
      end
      S_VBLANK: begin
        if (r_cnt == r_vblank) begin
          w_nxt_cnt   = '0;
          w_nxt_row   = '0;
          w_nxt_frame = r_frame + DATA_WIDTH'(1);
          // Free-run chains straight into the next front porch, no idle gap.
          if (en && mrst && !trig_mode) begin
            w_nxt_state = S_FPORCH;
            w_load      = 1'b1;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end else begin
          w_nxt_cnt = r_cnt + CNT_WIDTH'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // Master reset overrides everything on the next edge.
    if (!mrst) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
      w_nxt_row   = '0;
      w_nxt_frame = '0;
      w_load      = 1'b0;
      w_nxt_done  = 1'b0;
    end
  end

  // Outputs are computed from the next state so that, once registered, pxd
  // lines up with hact and the first active cycle carries column 0.
  always_comb begin
    w_nxt_vact = (w_nxt_state == S_FPORCH) || (w_nxt_state == S_LINE) ||
                 (w_nxt_state == S_HBLANK);
    w_nxt_hact = (w_nxt_state == S_LINE);
    unique case (r_pattern)
      2'd0:    w_pix = w_nxt_cnt[DATA_WIDTH-1:0];
      2'd1:    w_pix = w_nxt_row[DATA_WIDTH-1:0];
      2'd2:    w_pix = w_nxt_cnt[DATA_WIDTH-1:0] + w_nxt_row[DATA_WIDTH-1:0] + w_nxt_frame;
      default: w_pix = DATA_WIDTH'(12'hAAA);
    endcase
    if (!w_nxt_hact) w_pix = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_row        <= '0;
      r_frame      <= '0;
      r_hact_len   <= '0;
      r_vact_len   <= '0;
      r_hblank     <= '0;
      r_vblank     <= '0;
      r_pattern    <= '0;
      r_aro_meta   <= 1'b0;
      r_aro_sync   <= 1'b0;
      r_aro_dly    <= 1'b0;
      r_vact       <= 1'b0;
      r_hact       <= 1'b0;
      r_pxd        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_row        <= w_nxt_row;
      r_frame      <= w_nxt_frame;
      r_aro_meta   <= aro;
      r_aro_sync   <= r_aro_meta;
      r_aro_dly    <= r_aro_sync;
      r_vact       <= w_nxt_vact;
      r_hact       <= w_nxt_hact;
      r_pxd        <= w_pix;
      r_frame_done <= w_nxt_done;
      // Geometry is frozen for the whole frame from front-porch entry on.
      if (w_load) begin
        r_hact_len <= hact_length;
        r_vact_len <= vact_length;
        r_hblank   <= hblank;
        r_vblank   <= vblank;
        r_pattern  <= pattern;
      end
    end
  end

  assign vact       = r_vact;
  assign hact       = r_hact;
  assign pxd        = r_pxd;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sensor_emul_tx.sv
// -----------------------------------------------------------------------------
// tb_sensor_emul_tx
// Self-checking bench for sensor_emul_tx. A frame-level reference model builds
// the expected per-cycle {vact, hact, frame_done, pxd} stream of each frame
// from the geometry present when that frame starts; a small table of
// hand-computed per-frame totals and a few hand-written sequences cover
// trigger latency, master reset, enable drop and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_sensor_emul_tx;

  localparam int DW = 12;
  localparam int CW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          mrst;
  logic          aro;
  logic          en;
  logic          trig_mode;
  logic [CW-1:0] hact_length;
  logic [CW-1:0] vact_length;
  logic [CW-1:0] hblank;
  logic [CW-1:0] vblank;
  logic [1:0]    pattern;
  logic          vact;
  logic          hact;
  logic [DW-1:0] pxd;
  logic          frame_done;

  sensor_emul_tx #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .mrst        (mrst),
    .aro         (aro),
    .en          (en),
    .trig_mode   (trig_mode),
    .hact_length (hact_length),
    .vact_length (vact_length),
    .hblank      (hblank),
    .vblank      (vblank),
    .pattern     (pattern),
    .vact        (vact),
    .hact        (hact),
    .pxd         (pxd),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic        vact;
    logic        hact;
    logic        fd;
    logic [11:0] pxd;
  } cyc_t;

  typedef struct {
    logic [CW-1:0] hl, vl, hb, vb;
    logic [1:0]    pat;
    int            period, vact_n, hact_n, pxd_sum;
  } vec_t;

  cyc_t exp_q[$];
  int   m_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic void push(input logic v, input logic h, input logic f, input int p);
    cyc_t c;
    c.vact = v;
    c.hact = h;
    c.fd   = f;
    c.pxd  = 12'(p % 4096);
    exp_q.push_back(c);
  endfunction

  // One whole frame from the current inputs, described by the frame layout:
  // front porch, lines separated by horizontal blanks, then vertical blank.
  function automatic void gen_frame();
    int hl = int'(hact_length);
    int vl = int'(vact_length);
    int hb = int'(hblank);
    int vb = int'(vblank);
    int p;
    for (int i = 0; i <= hb; i++) push(1, 0, 0, 0);
    for (int r = 0; r <= vl; r++) begin
      for (int c = 0; c <= hl; c++) begin
        case (pattern)
          2'd0:    p = c;
          2'd1:    p = r;
          2'd2:    p = c + r + m_frame;
          default: p = 'hAAA;
        endcase
        push(1, 1, 0, p);
      end
      if (r < vl) for (int i = 0; i <= hb; i++) push(1, 0, 0, 0);
    end
    for (int i = 0; i <= vb; i++) push(0, 0, (i == 0), 0);
    m_frame = (m_frame + 1) % 4096;
  endfunction

  // Called at a negedge. regen=1 models free-run (a new frame follows at once);
  // with regen=0 an exhausted queue means the DUT must sit idle.
  task automatic run_model(input int n, input bit rand_geom, input bit regen);
    cyc_t e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0 && regen) gen_frame();
      @(posedge clk);
      @(negedge clk);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check("stream", 32'({vact, hact, frame_done, pxd}), 32'(e));
      if (rand_geom && $urandom_range(0, 15) == 0) begin
        hact_length = CW'($urandom_range(0, 7));
        vact_length = CW'($urandom_range(0, 3));
        hblank      = CW'($urandom_range(0, 3));
        vblank      = CW'($urandom_range(0, 3));
        pattern     = 2'($urandom_range(0, 3));
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    exp_q.delete();
    m_frame = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_geom(input int hl, input int vl, input int hb, input int vb, input int pat);
    hact_length = CW'(hl);
    vact_length = CW'(vl);
    hblank      = CW'(hb);
    vblank      = CW'(vb);
    pattern     = 2'(pat);
  endtask

  // Measures one full frame period, from the cycle after a frame_done pulse
  // up to and including the next one.
  task automatic measure(output int period, output int vn, output int hn, output int ps);
    int guard = 0;
    period = 0; vn = 0; hn = 0; ps = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!frame_done && guard < 300);
    if (guard >= 300) return;
    do begin
      @(negedge clk);
      period++;
      vn += int'(vact);
      hn += int'(hact);
      if (hact) ps += int'(pxd);
    end while (!frame_done && period < 1000);
  endtask

  vec_t vecs[4];
  int   per, vn, hn, ps;

  initial begin
    vecs[0] = '{hl: 3, vl: 1, hb: 2, vb: 4, pat: 0, period: 19, vact_n: 14, hact_n: 8, pxd_sum: 12};
    vecs[1] = '{hl: 0, vl: 0, hb: 0, vb: 0, pat: 3, period: 3,  vact_n: 2,  hact_n: 1, pxd_sum: 2730};
    vecs[2] = '{hl: 2, vl: 2, hb: 0, vb: 1, pat: 1, period: 14, vact_n: 12, hact_n: 9, pxd_sum: 9};
    vecs[3] = '{hl: 1, vl: 0, hb: 1, vb: 0, pat: 0, period: 5,  vact_n: 4,  hact_n: 2, pxd_sum: 1};

    rst = 1'b1; mrst = 1'b1; aro = 1'b0; en = 1'b1; trig_mode = 1'b0;
    set_geom(3, 1, 2, 4, 0);
    m_frame = 0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_vact", 32'(vact), 32'd0);
    check("rst_hact", 32'(hact), 32'd0);
    check("rst_pxd", 32'(pxd), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);

    // Table of free-run geometries with hand-computed per-frame totals.
    foreach (vecs[k]) begin
      set_geom(int'(vecs[k].hl), int'(vecs[k].vl), int'(vecs[k].hb), int'(vecs[k].vb), int'(vecs[k].pat));
      reset_dut();
      measure(per, vn, hn, ps);
      check($sformatf("vec%0d_period", k), 32'(per), 32'(vecs[k].period));
      check($sformatf("vec%0d_vact", k), 32'(vn), 32'(vecs[k].vact_n));
      check($sformatf("vec%0d_hact", k), 32'(hn), 32'(vecs[k].hact_n));
      check($sformatf("vec%0d_pxdsum", k), 32'(ps), 32'(vecs[k].pxd_sum));
    end

    // Randomized free-run with geometry changing mid-frame.
    set_geom(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    reset_dut();
    run_model(800, 1, 1);

    // Diagonal pattern over three long frames: column wraps past 4095.
    set_geom(4097, 1, 0, 0, 2);
    reset_dut();
    run_model(3 * 8199, 0, 1);

    // Master reset in the middle of a line of the second frame.
    set_geom(3, 1, 2, 4, 2);
    reset_dut();
    run_model(25, 0, 1);
    check("mrst_pre_hact", 32'(hact), 32'd1);
    mrst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mrst_vact", 32'(vact), 32'd0);
    check("mrst_hact", 32'(hact), 32'd0);
    check("mrst_pxd", 32'(pxd), 32'd0);
    @(posedge clk); @(negedge clk);
    mrst = 1'b1;
    exp_q.delete();
    m_frame = 0;
    run_model(40, 0, 1);

    // Trigger mode: latency, single frame, ignored second pulse.
    trig_mode = 1'b1;
    set_geom(3, 1, 2, 4, 0);
    reset_dut();
    repeat (4) @(negedge clk);
    check("trig_idle_vact", 32'(vact), 32'd0);
    aro = 1'b1;
    @(posedge clk); @(negedge clk);
    check("trig_n_vact", 32'(vact), 32'd0);
    @(posedge clk); @(negedge clk);
    check("trig_n1_vact", 32'(vact), 32'd0);
    run_model(1, 0, 1);
    aro = 1'b0;
    run_model(4, 0, 0);
    aro = 1'b1;
    run_model(3, 0, 0);
    aro = 1'b0;
    run_model(50, 0, 0);
    trig_mode = 1'b0;

    // en dropped during row 0: the frame completes, then idle.
    reset_dut();
    run_model(5, 0, 1);
    en = 1'b0;
    run_model(40, 0, 0);
    en = 1'b1;

    // Asynchronous reset between edges clears the outputs immediately.
    reset_dut();
    run_model(6, 0, 1);
    @(posedge clk);
    #3;
    check("arst_pre_hact", 32'(hact), 32'd1);
    rst = 1'b1;
    #1;
    check("arst_vact", 32'(vact), 32'd0);
    check("arst_hact", 32'(hact), 32'd0);
    check("arst_pxd", 32'(pxd), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
